// File: rtl/mc_control_unit.sv
// mc_control_unit -- multicycle RISC-V control unit (Moore FSM).
//
// Sequences each instruction through FETCH/DECODE/execute/writeback states
// and drives the datapath mux selects and register enables. Memory states
// wait on mem_ready under a bounded wait counter; an expired wait, an
// unknown opcode or an unsupported branch funct3 parks the unit in FAULT
// until reset.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   op, funct3, funct7_5  instruction register fields
//   Zero                  ALU zero flag (branch resolution)
//   mem_ready             memory completes the current request this cycle
//   MemReq, MemWrite      memory request / store strobe
//   PCWrite, IRWrite, RegWrite  register enables
//   AdrSrc                memory address select (0=PC, 1=Result)
//   ALUSrcA, ALUSrcB      ALU operand selects
//   ResultSrc, ImmSrc     result mux select / immediate format
//   ALUControl            ALU operation code
//   Retire                one-cycle pulse per completed instruction
//   Fault                 error flag, held until reset
//   state_o               current state code
module mc_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALUCTRL_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Retire,
    output logic                 Fault,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] ALU_PASSB = ALUCTRL_W'(9);
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(10);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nx;
    logic [7:0] wait_cnt;
    logic       mem_wait, timeout, br_ok;

    // Only beq/bne are supported; anything else in BRANCH is a fault.
    assign br_ok = (funct3 == 3'b000) || (funct3 == 3'b001);

    // mem_ready only means something while a request is outstanding.
    assign mem_wait = MemReq && !mem_ready;
    // This cycle would be the MEM_TIMEOUT-th unanswered one; a ready in the
    // same cycle still completes the access because mem_wait is then 0.
    assign timeout  = mem_wait && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:    if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_nx = S_MEMADR;
                    7'b0110011:             state_nx = S_EXECR;
                    7'b0010011:             state_nx = S_EXECI;
                    7'b1100011:             state_nx = S_BRANCH;
                    7'b1101111:             state_nx = S_JAL;
                    7'b0110111:             state_nx = S_LUI;
                    default:                state_nx = S_FAULT;
                endcase
            end
            S_MEMADR:   state_nx = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_nx = S_MEMWB;
            S_MEMWB:    state_nx = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_nx = S_FETCH;
            S_EXECR,
            S_EXECI:    state_nx = S_ALUWB;
            S_ALUWB:    state_nx = S_FETCH;
            S_BRANCH:   state_nx = br_ok ? S_FETCH : S_FAULT;
            S_JAL,
            S_LUI:      state_nx = S_ALUWB;
            default:    state_nx = S_FAULT;
        endcase
        if (timeout) state_nx = S_FAULT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nx;
            // Counter restarts on any completion or state change.
            wait_cnt <= (mem_wait && state_nx == state) ? wait_cnt + 8'd1 : 8'd0;
        end
    end

    // Moore decode; only the FETCH/BRANCH enables, the MEMWRITE retire and
    // the EXEC ALU op look at inputs.
    always_comb begin
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ResultSrc  = 2'd0;
        ImmSrc     = 3'd0;
        ALUControl = ALU_ADD;
        Retire     = 1'b0;
        Fault      = 1'b0;
        case (state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                // reset gating keeps the enables low while reset is held.
                IRWrite   = mem_ready && reset;
                PCWrite   = mem_ready && reset;
            end
            S_DECODE: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd1;
                ImmSrc  = 3'd2;
            end
            S_MEMADR: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd1;
                ImmSrc  = op[5] ? 3'd1 : 3'd0;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'd1;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                Retire   = mem_ready;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA = 2'd2;
                ALUSrcB = (state == S_EXECI) ? 2'd1 : 2'd0;
                case (funct3)
                    3'b000:  ALUControl = (state == S_EXECR && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  ALUControl = ALU_SLL;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b011:  ALUControl = ALU_SLTU;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b101:  ALUControl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  ALUControl = ALU_OR;
                    default: ALUControl = ALU_AND;
                endcase
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'd2;
                ALUControl = ALU_SUB;
                PCWrite    = (funct3 == 3'b000) ? Zero :
                             (funct3 == 3'b001) ? !Zero : 1'b0;
                Retire     = br_ok;
            end
            S_JAL: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                PCWrite = 1'b1;
            end
            S_LUI: begin
                ALUSrcB    = 2'd1;
                ImmSrc     = 3'd4;
                ALUControl = ALU_PASSB;
            end
            S_FAULT: Fault = 1'b1;
            default: Fault = 1'b1;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit -- randomized instruction-level check of mc_control_unit.
//
// Each instruction is expanded into the cycle-by-cycle trace the unit must
// follow (state sequence, memory wait/ready plan, enables, retire), then the
// trace is replayed against the DUT and every cycle's full output word is
// compared. Faults are followed by a reset and its output checks.
module tb_mc_control_unit;

    localparam int T = 4;  // MEM_TIMEOUT used for this instance

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
    logic       MemReq, MemWrite, PCWrite, IRWrite, RegWrite, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       Retire, Fault;
    logic [3:0] state_o;

    mc_control_unit #(.MEM_TIMEOUT(T), .ALUCTRL_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .mem_ready(mem_ready), .MemReq(MemReq), .MemWrite(MemWrite),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Retire(Retire), .Fault(Fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    logic [24:0] vec;
    assign vec = {state_o, MemReq, MemWrite, PCWrite, IRWrite, RegWrite, AdrSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Retire, Fault};

    typedef struct {
        int st;
        bit mem;
        bit rdy;
        bit pcw;
        bit irw;
        bit ret;
        int imm;
        int alu;
    } cyc_t;

    cyc_t tr[$];
    bit   tr_fault;
    int   n_chk = 0, n_err = 0, ins_no = 0;
    logic [6:0] ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b1101111, 7'b0110111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Fixed per-state select/enable values; instruction-dependent fields
    // (imm, alu, pcw, irw, ret) come from the trace entry.
    function automatic logic [24:0] exp_vec(input cyc_t e);
        logic mreq, mwr, rw, adr, flt;
        logic [1:0] sa, sb, rs;
        mreq = 0; mwr = 0; rw = 0; adr = 0; flt = 0; sa = 0; sb = 0; rs = 0;
        case (e.st)
            0:  begin mreq = 1; sb = 2; rs = 2; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  begin mreq = 1; adr = 1; end
            4:  begin rs = 1; rw = 1; end
            5:  begin mreq = 1; mwr = 1; adr = 1; end
            6:  sa = 2;
            7:  begin sa = 2; sb = 1; end
            8:  rw = 1;
            9:  sa = 2;
            10: begin sa = 1; sb = 2; end
            11: sb = 1;
            15: flt = 1;
            default: ;
        endcase
        return {4'(e.st), mreq, mwr, e.pcw, e.irw, rw, adr, sa, sb, rs,
                3'(e.imm), 4'(e.alu), e.ret, flt};
    endfunction

    task automatic push(input int st, input bit mem, input bit rdy, input bit pcw,
                        input bit irw, input bit ret, input int imm, input int alu);
        cyc_t e;
        e.st = st; e.mem = mem; e.rdy = rdy; e.pcw = pcw;
        e.irw = irw; e.ret = ret; e.imm = imm; e.alu = alu;
        tr.push_back(e);
    endtask

    task automatic fault_tail();
        tr_fault = 1;
        for (int i = 0; i < 3; i++) push(15, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Memory state with 'waits' unanswered cycles; T of them is a timeout.
    task automatic mem_phase(input int st, input int waits, output bit ok);
        if (waits >= T) begin
            for (int i = 0; i < T; i++) push(st, 1, 0, 0, 0, 0, 0, 0);
            fault_tail();
            ok = 0;
        end else begin
            for (int i = 0; i < waits; i++) push(st, 1, 0, 0, 0, 0, 0, 0);
            push(st, 1, 1, st == 0, st == 0, st == 5, 0, 0);
            ok = 1;
        end
    endtask

    function automatic int alu_of(input int f3, input bit f7, input bit is_r);
        case (f3)
            0: return (is_r && f7) ? 1 : 0;
            1: return 6;
            2: return 5;
            3: return 10;
            4: return 4;
            5: return f7 ? 8 : 7;
            6: return 3;
            default: return 2;
        endcase
    endfunction

    // kind: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal, 6 lui, 7 illegal
    task automatic build(input int kind, input int f3, input bit f7, input bit z,
                         input int fw, input int mw);
        bit ok, bvalid;
        tr.delete();
        tr_fault = 0;
        mem_phase(0, fw, ok);
        if (!ok) return;
        push(1, 0, 0, 0, 0, 0, 2, 0);
        case (kind)
            0: begin
                push(2, 0, 0, 0, 0, 0, 0, 0);
                mem_phase(3, mw, ok);
                if (ok) push(4, 0, 0, 0, 0, 1, 0, 0);
            end
            1: begin
                push(2, 0, 0, 0, 0, 0, 1, 0);
                mem_phase(5, mw, ok);
            end
            2: begin push(6, 0, 0, 0, 0, 0, 0, alu_of(f3, f7, 1)); push(8, 0, 0, 0, 0, 1, 0, 0); end
            3: begin push(7, 0, 0, 0, 0, 0, 0, alu_of(f3, f7, 0)); push(8, 0, 0, 0, 0, 1, 0, 0); end
            4: begin
                bvalid = (f3 < 2);
                push(9, 0, 0, bvalid && ((f3 == 0) ? z : !z), 0, bvalid, 0, 1);
                if (!bvalid) fault_tail();
            end
            5: begin push(10, 0, 0, 1, 0, 0, 0, 0); push(8, 0, 0, 0, 0, 1, 0, 0); end
            6: begin push(11, 0, 0, 0, 0, 0, 4, 9); push(8, 0, 0, 0, 0, 1, 0, 0); end
            default: fault_tail();
        endcase
    endtask

    // Replay up to 'limit' trace cycles; phase is posedge+1 on entry and exit.
    task automatic run(input int limit);
        for (int i = 0; i < tr.size() && i < limit; i++) begin
            mem_ready = tr[i].mem ? tr[i].rdy : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("i%0d_c%0d_st%0d", ins_no, i, tr[i].st), 32'(vec), 32'(exp_vec(tr[i])));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        cyc_t r;
        r.st = 0; r.mem = 0; r.rdy = 0; r.pcw = 0; r.irw = 0; r.ret = 0; r.imm = 0; r.alu = 0;
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk({tag, "_async"}, 32'(vec), 32'(exp_vec(r)));
        @(posedge clk);
        #1;
        chk({tag, "_hold"}, 32'(vec), 32'(exp_vec(r)));
        reset = 1'b1;
        mem_ready = 1'b0;
    endtask

    task automatic do_ins(input int kind, input logic [6:0] o, input int f3, input bit f7,
                          input bit z, input int fw, input int mw);
        ins_no++;
        op = o; funct3 = 3'(f3); funct7_5 = f7; Zero = z;
        build(kind, f3, f7, z, fw, mw);
        run(1000);
        if (tr_fault) do_reset($sformatf("i%0d_rst", ins_no));
    endtask

    function automatic int rnd_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return r % 3;
        if (r < 19) return 3;
        return 4;
    endfunction

    initial begin
        int k, f3;
        logic [6:0] o;
        #1;
        do_reset("por");

        do_ins(2, ops[2], 0, 0, 0, 0, 0);   // add x3,x1,x2
        do_ins(0, ops[0], 2, 0, 0, 0, 3);   // lw, ready on last allowed cycle
        do_ins(4, ops[4], 0, 0, 1, 0, 0);   // beq, Zero=1 -> taken
        do_ins(4, ops[4], 1, 0, 1, 0, 0);   // bne, Zero=1 -> not taken
        do_ins(5, ops[5], 0, 0, 0, 1, 0);   // jal
        do_ins(6, ops[6], 0, 0, 0, 2, 0);   // lui
        do_ins(3, ops[3], 5, 1, 0, 0, 0);   // srai
        do_ins(2, ops[2], 0, 1, 0, 0, 0);   // sub
        do_ins(1, ops[1], 2, 0, 0, 0, 1);   // sw
        do_ins(2, ops[2], 0, 0, 0, 4, 0);   // fetch timeout
        do_ins(7, 7'b1111111, 0, 0, 0, 0, 0); // illegal opcode
        do_ins(4, ops[4], 4, 0, 0, 0, 0);   // unsupported branch
        do_ins(0, ops[0], 2, 0, 0, 0, 4);   // load timeout
        do_ins(1, ops[1], 2, 0, 0, 0, 4);   // store timeout

        // Reset in the middle of a store wait.
        ins_no++;
        op = ops[1]; funct3 = 3'd2; funct7_5 = 0; Zero = 0;
        build(1, 2, 0, 0, 0, 2);
        run(4);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state_o), 32'd0);
        chk("mid_rst_memwrite", 32'(MemWrite), 32'd0);
        chk("mid_rst_memreq", 32'(MemReq), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Counter must have been cleared: full three-wait fetch still succeeds.
        do_ins(2, ops[2], 7, 0, 0, 3, 0);

        repeat (250) begin
            k = $urandom_range(0, 7);
            if (k == 7 && $urandom_range(0, 1) == 1) k = $urandom_range(0, 6);
            f3 = $urandom_range(0, 7);
            if (k == 4 && $urandom_range(0, 3) != 0) f3 = f3 & 1;
            if (k == 7) begin
                o = 7'($urandom);
                for (int j = 0; j < 7; j++) if (o == ops[j]) o = 7'b1111111;
            end else begin
                o = ops[k];
            end
            do_ins(k, o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   rnd_wait(), rnd_wait());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
